ccd_edge_filter: RTL and testbench
==================================

Name: ccd_edge_filter

Overview:
Streaming pixel pre-processor on the camera (CCD) side, ahead of the CCD input FIFO of the SRAM frame-buffer controller. Each cycle it can accept one 30-bit RGB pixel (3x10 bit). It outputs either the pixel unchanged (bypass) or a 3x3 Sobel edge magnitude of the grey-scale image. The edge magnitude is replicated into all three colour channels. It holds two internal line buffers, so it needs no external memory.

Parameters:
LINE_WIDTH, 800, pixels per input line; sets the depth of each line buffer.
PIX_W, 10, bits per colour channel; the pixel word is 3*PIX_W bits wide.

Ports:
CCD_FIFO_WRCLK  in  1  clock, pixel domain
RESET_N  in  1  asynchronous active-low reset
iEDGE_EN  in  1  1 = Sobel edge output, 0 = bypass
iPIX_DATA  in  30  input pixel {R[29:20], G[19:10], B[9:0]}
iPIX_VALID  in  1  input pixel strobe (CCD FIFO write enable)
oPIX_DATA  out  30  output pixel, same packing as iPIX_DATA; drives the CCD FIFO data input
oPIX_VALID  out  1  output strobe; drives the CCD FIFO write request

Behaviour:
- Interface: reset RESET_N, asynchronous, active-low; clock CCD_FIFO_WRCLK. All logic is rising-edge.
- Reset values:
  - oPIX_DATA = 0, oPIX_VALID = 0.
  - All pipeline valid bits = 0.
  - 3x3 window registers = 0.
  - Line-buffer RAM contents are not reset (undefined).
- Pipeline: fixed latency of 3 cycles in both modes.
  - oPIX_VALID(t+3) = iPIX_VALID(t).
  - oPIX_DATA(t+3) is the result for the pixel presented at t.
  - There is no backpressure: the downstream FIFO full flag is handled upstream by the writer.
- Mode select:
  - iEDGE_EN is sampled together with each pixel at stage 1 and travels down the pipeline with it.
  - A mode change therefore takes effect on a per-pixel basis; no flush is needed.
- Stage 1 (grey conversion):
  - gray = floor((R+G+B)/3), computed with a 12-bit sum; result is 10 bits.
  - The raw pixel and the mode bit are registered alongside gray.
- Stage 2 (window shift), only when the stage-1 valid bit is 1:
  - Window columns shift left by one; the new pixel enters the rightmost column.
  - Row 2 (newest line) takes the new gray value.
  - Row 1 takes line buffer A output; row 0 (oldest line) takes line buffer B output.
  - Buffer A input is the new gray value; buffer B input is buffer A output.
  - Each buffer is a LINE_WIDTH-deep shift (RAM plus circular pointer) that advances only on valid pixels. Gaps in iPIX_VALID therefore do not corrupt line alignment.
  - Each circular pointer wraps from LINE_WIDTH-1 to 0.
- Stage 3 (Sobel), window w[r][c] with r=0 the oldest line and c=0 the oldest column:
  - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20)
  - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02)
  - Gx and Gy are signed, at least 13 bits.
  - mag = |Gx| + |Gy|, range 0..8184, saturated to 1023.
  - Edge output = {mag, mag, mag}.
  - Bypass output = the raw pixel, delayed 3 cycles.
- Output alignment: no spatial re-centring and no border handling.
  - Output n is the window whose newest sample is input n; its centre is input n-LINE_WIDTH-1.
  - Outputs for the first 2*LINE_WIDTH+2 valid pixels after reset, and across the left/right image borders, are don't-care in edge mode.
  - Bypass outputs are always exact.
- Reset mid-stream: all in-flight pixels are discarded and oPIX_VALID drops to 0 asynchronously. Line-buffer pointers reset to 0.
- Idle cycles (iPIX_VALID = 0): oPIX_VALID = 0 three cycles later, and oPIX_DATA holds its last value.

Test Plan:
1. Bypass: iEDGE_EN=0, feed pixels 0x3FFFFFFF, 0x12345678&0x3FFFFFFF, 0 on consecutive cycles -> the same words appear with oPIX_VALID=1 exactly 3 cycles later, in order.
2. Flat image: iEDGE_EN=1, LINE_WIDTH=8, feed 4 lines of all pixels {100,100,100} -> after 2*8+2 warm-up pixels every output is 0.
3. Vertical step: LINE_WIDTH=8, columns 0-3 = 0 and columns 4-7 = {100,100,100}, 4 lines -> the output whose window straddles the step = {400,400,400} (Gx=400, Gy=0); windows fully inside either flat region = 0.
4. Saturation/grey: horizontal step from 0 to {1023,1023,1023} -> |Gy| = 4092, output saturates to {1023,1023,1023}. Pixel {30,60,91} converts to gray 60.
5. Valid gaps: repeat scenario 3 with iPIX_VALID=0 inserted on every other cycle -> identical output sequence; oPIX_VALID mirrors the input pattern delayed by 3 cycles.
6. Reset mid-stream: assert RESET_N=0 during streaming -> oPIX_VALID=0 and oPIX_DATA=0 immediately (asynchronously). After release, bypass pixels pass through correctly with 3-cycle latency.

Source files
------------

// File: rtl/ccd_edge_filter.sv
// ccd_edge_filter
// Streaming pixel pre-processor placed in front of the CCD input FIFO.
// Each valid cycle accepts one RGB pixel and, three cycles later, emits
// either the same pixel (bypass) or the 3x3 Sobel edge magnitude of the
// grey-scale image replicated into all three channels (edge mode).
// Two internal line buffers provide the two previous image lines.
//
// Ports:
//   CCD_FIFO_WRCLK  in   pixel clock, all logic on the rising edge
//   RESET_N         in   asynchronous active-low reset
//   iEDGE_EN        in   1 = Sobel output, 0 = bypass (sampled per pixel)
//   iPIX_DATA       in   {R, G, B}, PIX_W bits each
//   iPIX_VALID      in   input pixel strobe
//   oPIX_DATA       out  result pixel, same packing as iPIX_DATA
//   oPIX_VALID      out  result strobe, iPIX_VALID delayed by 3 cycles
module ccd_edge_filter #(
  parameter int LINE_WIDTH = 800,
  parameter int PIX_W      = 10
) (
  input  logic                 CCD_FIFO_WRCLK,
  input  logic                 RESET_N,
  input  logic                 iEDGE_EN,
  input  logic [3*PIX_W-1:0]   iPIX_DATA,
  input  logic                 iPIX_VALID,
  output logic [3*PIX_W-1:0]   oPIX_DATA,
  output logic                 oPIX_VALID
);

  localparam int PTR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int SUM_W = PIX_W + 2;
  // Gradients reach +/-4*max_pixel; the sum of magnitudes reaches 8*max_pixel.
  localparam int G_W   = PIX_W + 4;
  localparam logic [G_W-1:0] SAT_MAX = G_W'((1 << PIX_W) - 1);

  // ---------------------------------------------------------------------
  // Stage 1: grey conversion, line-buffer read issue
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0] w_sum;
  logic [PIX_W-1:0] w_gray;

  assign w_sum  = SUM_W'(iPIX_DATA[3*PIX_W-1 -: PIX_W])
                + SUM_W'(iPIX_DATA[2*PIX_W-1 -: PIX_W])
                + SUM_W'(iPIX_DATA[PIX_W-1:0]);
  assign w_gray = PIX_W'(w_sum / SUM_W'(3));

  logic               r_s1_valid;
  logic               r_s1_mode;
  logic [3*PIX_W-1:0] r_s1_pix;
  logic [PIX_W-1:0]   r_s1_gray;
  logic [PTR_W-1:0]   r_s1_addr;
  logic [PTR_W-1:0]   r_ptr;

  // r_ptr is the line-buffer slot the next valid pixel will use. The slot
  // is read in stage 1 and rewritten in stage 2, so each buffer behaves as
  // a LINE_WIDTH-deep shift register that only advances on valid pixels.
  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_gray  <= '0;
      r_s1_addr  <= '0;
      r_ptr      <= '0;
    end else begin
      r_s1_valid <= iPIX_VALID;
      if (iPIX_VALID) begin
        r_s1_mode <= iEDGE_EN;
        r_s1_pix  <= iPIX_DATA;
        r_s1_gray <= w_gray;
        r_s1_addr <= r_ptr;
        r_ptr     <= (r_ptr == PTR_W'(LINE_WIDTH - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Line buffers: block RAM with registered read, contents never reset.
  // Read address (r_ptr) and write address (r_s1_addr) always differ by
  // one slot, so there is no read/write collision for LINE_WIDTH >= 2.
  // ---------------------------------------------------------------------
  logic [PIX_W-1:0] r_lb_a [LINE_WIDTH];
  logic [PIX_W-1:0] r_lb_b [LINE_WIDTH];
  logic [PIX_W-1:0] r_rd_a;
  logic [PIX_W-1:0] r_rd_b;

  always_ff @(posedge CCD_FIFO_WRCLK) begin
    if (iPIX_VALID) begin
      r_rd_a <= r_lb_a[r_ptr];
      r_rd_b <= r_lb_b[r_ptr];
    end
    if (r_s1_valid) begin
      r_lb_a[r_s1_addr] <= r_s1_gray;
      r_lb_b[r_s1_addr] <= r_rd_a;    // B is fed by what falls out of A
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: 3x3 window shift. r_win[row][col], row 0 = oldest line,
  // col 0 = oldest column; new samples enter column 2.
  // ---------------------------------------------------------------------
  logic [PIX_W-1:0]   w_row_in [3];
  logic [PIX_W-1:0]   r_win [3][3];
  logic               r_s2_valid;
  logic               r_s2_mode;
  logic [3*PIX_W-1:0] r_s2_pix;

  assign w_row_in[0] = r_rd_b;
  assign w_row_in[1] = r_rd_a;
  assign w_row_in[2] = r_s1_gray;

  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_pix   <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_pix  <= r_s1_pix;
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= w_row_in[r];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: Sobel magnitude and output register
  // ---------------------------------------------------------------------
  function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({{(G_W - PIX_W){1'b0}}, v});
  endfunction

  logic signed [G_W-1:0] w_gx;
  logic signed [G_W-1:0] w_gy;
  logic [G_W-1:0]        w_ax;
  logic [G_W-1:0]        w_ay;
  logic [G_W-1:0]        w_mag;
  logic [PIX_W-1:0]      w_edge;

  assign w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
  assign w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));

  assign w_ax   = w_gx[G_W-1] ? G_W'(-w_gx) : G_W'(w_gx);
  assign w_ay   = w_gy[G_W-1] ? G_W'(-w_gy) : G_W'(w_gy);
  assign w_mag  = w_ax + w_ay;
  assign w_edge = (w_mag > SAT_MAX) ? '1 : w_mag[PIX_W-1:0];

  logic [3*PIX_W-1:0] r_out_data;
  logic               r_out_valid;

  // Data only updates on valid results so idle cycles hold the last word.
  always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= r_s2_mode ? {3{w_edge}} : r_s2_pix;
      end
    end
  end

  assign oPIX_DATA  = r_out_data;
  assign oPIX_VALID = r_out_valid;

endmodule

// File: tb/tb_ccd_edge_filter.sv
// Directed testbench for ccd_edge_filter with an 8-pixel line.
module tb_ccd_edge_filter;

  localparam int LW = 8;

  logic        clk;
  logic        rst_n;
  logic        edge_en;
  logic [29:0] pix_in;
  logic        valid_in;
  logic [29:0] pix_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  int          cyc;
  logic        hv [0:1023];
  logic [29:0] out_q [$];

  ccd_edge_filter #(.LINE_WIDTH(LW), .PIX_W(10)) dut (
    .CCD_FIFO_WRCLK (clk),
    .RESET_N        (rst_n),
    .iEDGE_EN       (edge_en),
    .iPIX_DATA      (pix_in),
    .iPIX_VALID     (valid_in),
    .oPIX_DATA      (pix_out),
    .oPIX_VALID     (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] pix3(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic logic [29:0] rep3(input int v);
    return {10'(v), 10'(v), 10'(v)};
  endfunction

  // One clock cycle: sample outputs on the falling edge, then drive inputs.
  task automatic step(input logic v, input logic [29:0] d, input logic en);
    logic exp_v;
    @(negedge clk);
    exp_v = (cyc >= 3) ? hv[cyc-3] : 1'b0;
    check_val($sformatf("valid@%0d", cyc), {31'b0, valid_out}, {31'b0, exp_v});
    if (valid_out) out_q.push_back(pix_out);
    valid_in = v;
    pix_in   = d;
    edge_en  = en;
    hv[cyc]  = v;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 30'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pix_in   = '0;
    edge_en  = 1'b0;
    @(negedge clk);
    check_val("rst_valid", {31'b0, valid_out}, 32'h0);
    check_val("rst_data", {2'b0, pix_out}, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
    out_q.delete();
  endtask

  function automatic logic [29:0] got_at(input int n);
    return (n < out_q.size()) ? out_q[n] : 30'h2EADBEEF;
  endfunction

  // Vertical step: columns 0-3 black, 4-7 = p; four lines. Windows whose
  // newest column is 4 or 5 straddle the step (Gx = 4*gray).
  task automatic run_vstep(input string tag, input logic [29:0] p, input int mag, input bit gaps);
    do_reset();
    for (int n = 0; n < 4*LW; n++) begin
      step(1'b1, ((n % LW) < 4) ? 30'h0 : p, 1'b1);
      if (gaps) step(1'b0, 30'h0, 1'b1);
    end
    idle(4);
    check_val({tag, "_count"}, out_q.size(), 4*LW);
    for (int n = 2*LW+2; n < 4*LW; n++) begin
      int c;
      c = n % LW;
      if (c >= 2)
        check_val($sformatf("%s_out%0d", tag, n), {2'b0, got_at(n)},
                  {2'b0, ((c == 4) || (c == 5)) ? rep3(mag) : 30'h0});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pix_in   = '0;
    edge_en  = 1'b0;
    cyc      = 0;

    // 1. Bypass latency and ordering
    do_reset();
    step(1'b1, 30'h3FFFFFFF, 1'b0);
    step(1'b1, 30'h12345678, 1'b0);
    step(1'b1, 30'h0, 1'b0);
    idle(4);
    check_val("byp_count", out_q.size(), 3);
    check_val("byp0", {2'b0, got_at(0)}, 32'h3FFFFFFF);
    check_val("byp1", {2'b0, got_at(1)}, 32'h12345678);
    check_val("byp2", {2'b0, got_at(2)}, 32'h0);

    // 2. Flat image, plus a per-pixel switch to bypass at pixel 30
    do_reset();
    for (int n = 0; n < 4*LW; n++) step(1'b1, pix3(100, 100, 100), (n != 30));
    idle(4);
    check_val("flat_count", out_q.size(), 4*LW);
    for (int n = 2*LW+2; n < 4*LW; n++)
      check_val($sformatf("flat_out%0d", n), {2'b0, got_at(n)},
                {2'b0, (n == 30) ? pix3(100, 100, 100) : 30'h0});

    // 3. Vertical step, gray 100 -> 400
    run_vstep("vstep", pix3(100, 100, 100), 400, 1'b0);

    // 4a. Grey conversion: (30+60+91)/3 = 60 -> edge 240
    run_vstep("grey", pix3(30, 60, 91), 240, 1'b0);

    // 4b. Horizontal step 0 -> 1023: |Gy| = 4092, saturates to 1023
    do_reset();
    for (int n = 0; n < 4*LW; n++)
      step(1'b1, (n < 2*LW) ? 30'h0 : pix3(1023, 1023, 1023), 1'b1);
    idle(4);
    check_val("sat_count", out_q.size(), 4*LW);
    for (int n = 2*LW+2; n < 4*LW; n++)
      check_val($sformatf("sat_out%0d", n), {2'b0, got_at(n)}, {2'b0, rep3(1023)});

    // 5. Same as 3 with an idle cycle after every pixel
    run_vstep("gaps", pix3(100, 100, 100), 400, 1'b1);

    // 6. Reset mid-stream, then recovery and hold on idle
    do_reset();
    step(1'b1, 30'h11111111, 1'b0);
    step(1'b1, 30'h22222222, 1'b0);
    step(1'b1, 30'h33333333, 1'b0);
    step(1'b1, 30'h04444444, 1'b0);
    @(posedge clk);
    #2;
    check_val("pre_rst_valid", {31'b0, valid_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", {31'b0, valid_out}, 32'h0);
    check_val("async_rst_data", {2'b0, pix_out}, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;
    cyc      = 0;
    out_q.delete();
    step(1'b1, 30'h2A5A5A5A, 1'b0);
    step(1'b1, 30'h15A5A5A5, 1'b0);
    step(1'b1, 30'h0ABCDEF1, 1'b0);
    idle(6);
    check_val("rec_count", out_q.size(), 3);
    check_val("rec0", {2'b0, got_at(0)}, 32'h2A5A5A5A);
    check_val("rec1", {2'b0, got_at(1)}, 32'h15A5A5A5);
    check_val("rec2", {2'b0, got_at(2)}, 32'h0ABCDEF1);
    check_val("hold_data", {2'b0, pix_out}, 32'h0ABCDEF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
